ste_avg_fir_mc: RTL and testbench
=================================

Name: ste_avg_fir_mc

Overview:
Multi-channel boxcar (moving-average) FIR for the multimeter measurement path; successor to the single-channel averaging stub.
- Averages the last 2^win_log2_i samples per channel, with the window selectable at runtime.
- Channels are time-multiplexed over one input with a channel tag.
- Sits between the ADC sample formatter and the display/scaling stage.

Parameters:
DATA_W, 16, unsigned sample width
NUM_CH, 4, number of channels (>=1)
MAX_LOG2, 4, log2 of max window depth (buffer depth DEPTH=2^MAX_LOG2 per channel)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
din_i  input  DATA_W  input sample (unsigned)
din_ch_i  input  CH_W=max(1,$clog2(NUM_CH))  channel of din_i
din_update_i  input  1  sample strobe, one cycle
ready_o  output  1  block can accept a sample this cycle
win_log2_i  input  $clog2(MAX_LOG2+1)  window = 2^win_log2_i; values >MAX_LOG2 clamp to MAX_LOG2
avg_clr_i  input  1  clear all channel histories
dout_o  output  DATA_W  averaged data
dout_ch_o  output  CH_W  channel of dout_o
dout_update_o  output  1  one-cycle strobe, dout_o/dout_ch_o valid
ovr_o  output  1  sticky overrun flag

Behaviour:
- Reset (rst=1, async): dout_o=0, dout_ch_o=0, dout_update_o=0, ready_o=1, ovr_o=0; all sums, fill counters and write pointers 0; registered window = 0. Buffer RAM content is not reset.
- Per-channel state:
  - ring buffer of DEPTH samples (one RAM of NUM_CH*DEPTH words, synchronous read);
  - write pointer (MAX_LOG2 bits, wraps DEPTH-1 -> 0);
  - fill counter (saturates at DEPTH);
  - running sum, width DATA_W+MAX_LOG2 (never overflows).
- FSM IDLE -> READ -> UPD -> IDLE.
  - IDLE: ready_o=1. Sample accepted on din_update_i=1 && ready_o=1: latch din_i/din_ch_i, go READ.
  - READ: ready_o=0. RAM read of oldest sample at (wptr - W) mod DEPTH, W=2^win.
  - UPD: ready_o=0.
    - sum += new - (fill>=W ? old : 0); write new at wptr; wptr++; fill = min(fill+1, DEPTH).
    - If the new fill >= W: dout_o = sum_new >> win, dout_ch_o = channel, dout_update_o=1. Otherwise no strobe and dout_o holds.
    - Return to IDLE.
- Latency: dout_update_o asserts exactly 3 cycles after the accepting din_update_i edge. Maximum throughput is one sample per 3 cycles.
- Overrun: din_update_i=1 while ready_o=0 drops the sample and sets ovr_o=1. ovr_o is cleared only by avg_clr_i or rst.
- avg_clr_i (synchronous, highest priority):
  - Zeroes all sums, fills and pointers; dout_o=0; ovr_o=0; FSM to IDLE.
  - Any in-flight sample is discarded (no dout_update_o).
  - A simultaneous din_update_i is ignored and does not count as overrun.
- Window change: win_log2_i is registered each cycle. If the clamped value differs from the registered value, an internal clear identical to avg_clr_i occurs on the next cycle.
- W=1 (win=0): output equals input, with a strobe from the first sample.
- din_ch_i >= NUM_CH: sample ignored (no state change, no strobe, no ovr).
- Outputs are registered; no combinational path from input to output.

Optional Feature:
Macro STE_AVG_FIR_ROUND_EN.
- Defined: dout_o = (sum + 2^(win-1)) >> win (round half up). For win=0 there is no offset. The result is saturated to 2^DATA_W-1.
- Undefined: truncating shift only, with no rounding adder.

Test Plan:
1. rst pulse mid-UPD -> all outputs 0 immediately; ready_o=1; a following sample on ch0 with win=0 yields dout_o=sample, dout_update_o 3 cycles later.
2. win=1, ch0 samples 10, 20, 30 (spaced 4 cycles) -> no strobe after 10; dout_o=15 after 20; dout_o=25 after 30; dout_ch_o=0.
3. win=2, interleaved ch0 {4,8,12,16} and ch2 {100,100,100,100} -> single strobe per channel after its 4th sample: ch0 dout_o=10, ch2 dout_o=100.
4. din_update_i one cycle after an accepted sample -> sample dropped, ovr_o=1 sticky; avg_clr_i -> ovr_o=0, dout_o=0; the next 2^win samples are needed before the next strobe.
5. win=4, 16x 0xFFFF on ch1 then win_log2_i changed to 3 -> strobe dout_o=0xFFFF; after the change, fills are reset and there is no strobe until 8 new samples.
6. win=1, samples 10, 11: without the macro dout_o=10; with STE_AVG_FIR_ROUND_EN, dout_o=11.

Source files
------------

// File: rtl/ste_avg_fir_mc.sv
// ste_avg_fir_mc: multi-channel runtime-window boxcar averager, time-multiplexed over one sample input.
// Define STE_AVG_FIR_ROUND_EN for round-half-up output instead of truncation.
module ste_avg_fir_mc #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int MAX_LOG2 = 4,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int WIN_W = $clog2(MAX_LOG2 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_i,
  input  logic [CH_W-1:0]   din_ch_i,
  input  logic              din_update_i,
  output logic              ready_o,
  input  logic [WIN_W-1:0]  win_log2_i,
  input  logic              avg_clr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CH_W-1:0]   dout_ch_o,
  output logic              dout_update_o,
  output logic              ovr_o
);
  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int SW = DATA_W + MAX_LOG2;
  localparam int FW = MAX_LOG2 + 1;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_UPD} state_t;
  state_t r_state, w_nxt;
  logic [DATA_W-1:0]   r_mem [NUM_CH*DEPTH];
  logic [SW-1:0]       r_sum [NUM_CH];
  logic [FW-1:0]       r_fill [NUM_CH];
  logic [MAX_LOG2-1:0] r_wptr [NUM_CH];
  logic [WIN_W-1:0]    r_win, w_win;
  logic [DATA_W-1:0]   r_din, r_old, w_avg;
  logic [CH_W-1:0]     r_ch;
  logic                w_clr, w_valid, w_acc, w_ovr, w_full, w_strb;
  logic [FW-1:0]       w_w, w_fill;
  logic [MAX_LOG2-1:0] w_rptr;
  logic [SW-1:0]       w_sum;
  assign w_win = win_log2_i > WIN_W'(MAX_LOG2) ? WIN_W'(MAX_LOG2) : win_log2_i;
  assign w_clr = avg_clr_i | (w_win != r_win);
  assign w_valid = {1'b0, din_ch_i} < (CH_W+1)'(NUM_CH);
  assign w_acc = din_update_i & w_valid & (r_state == S_IDLE) & ~w_clr;
  assign w_ovr = din_update_i & w_valid & (r_state != S_IDLE) & ~w_clr;
  assign ready_o = r_state == S_IDLE;
  // A full-depth window wraps the oldest slot onto the write pointer itself.
  assign w_w = FW'(1) << r_win;
  assign w_rptr = r_wptr[r_ch] - w_w[MAX_LOG2-1:0];
  assign w_full = r_fill[r_ch] >= w_w;
  assign w_sum = r_sum[r_ch] + SW'(r_din) - (w_full ? SW'(r_old) : '0);
  assign w_fill = r_fill[r_ch] == FW'(DEPTH) ? r_fill[r_ch] : r_fill[r_ch] + FW'(1);
  assign w_strb = w_fill >= w_w;
`ifdef STE_AVG_FIR_ROUND_EN
  logic [SW:0] w_rnd;
  assign w_rnd = ({1'b0, w_sum} + (r_win == '0 ? '0 : (SW+1)'(1) << (r_win - 1'b1))) >> r_win;
  assign w_avg = (w_rnd >> DATA_W) != '0 ? '1 : DATA_W'(w_rnd);
`else
  assign w_avg = DATA_W'(w_sum >> r_win);
`endif
  always_comb begin
    w_nxt = S_IDLE;
    if (!w_clr)
      w_nxt = r_state == S_IDLE ? (w_acc ? S_READ : S_IDLE) : r_state == S_READ ? S_UPD : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge clk) begin
    if (r_state == S_READ) r_old <= r_mem[{r_ch, w_rptr}];
    if (r_state == S_UPD) r_mem[{r_ch, r_wptr[r_ch]}] <= r_din;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_win <= '0;
      r_din <= '0;
      r_ch <= '0;
      dout_o <= '0;
      dout_ch_o <= '0;
      dout_update_o <= 1'b0;
      ovr_o <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_sum[i] <= '0;
        r_fill[i] <= '0;
        r_wptr[i] <= '0;
      end
    end else begin
      r_win <= w_win;
      dout_update_o <= 1'b0;
      if (w_clr) begin
        dout_o <= '0;
        ovr_o <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          r_sum[i] <= '0;
          r_fill[i] <= '0;
          r_wptr[i] <= '0;
        end
      end else begin
        if (w_ovr) ovr_o <= 1'b1;
        if (w_acc) begin
          r_din <= din_i;
          r_ch <= din_ch_i;
        end
        if (r_state == S_UPD) begin
          r_sum[r_ch] <= w_sum;
          r_fill[r_ch] <= w_fill;
          r_wptr[r_ch] <= r_wptr[r_ch] + 1'b1;
          if (w_strb) begin
            dout_o <= w_avg;
            dout_ch_o <= r_ch;
            dout_update_o <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_ste_avg_fir_mc.sv
// tb_ste_avg_fir_mc: randomized and directed checks of ste_avg_fir_mc against a per-channel history model.
module tb_ste_avg_fir_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] din_i = '0;
  logic [1:0] din_ch_i = '0;
  logic din_update_i = 1'b0;
  logic ready_o;
  logic [2:0] win_log2_i = '0;
  logic avg_clr_i = 1'b0;
  logic [15:0] dout_o;
  logic [1:0] dout_ch_o;
  logic dout_update_o;
  logic ovr_o;
  int n_tests = 0;
  int n_fail = 0;
  int unsigned hist [4][$];
  int cur_win = 0;
  int last_dout = 0;
  ste_avg_fir_mc dut (
    .clk(clk), .rst(rst), .din_i(din_i), .din_ch_i(din_ch_i), .din_update_i(din_update_i),
    .ready_o(ready_o), .win_log2_i(win_log2_i), .avg_clr_i(avg_clr_i), .dout_o(dout_o),
    .dout_ch_o(dout_ch_o), .dout_update_o(dout_update_o), .ovr_o(ovr_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int c = 0; c < 4; c++) hist[c].delete();
    last_dout = 0;
  endtask
  task automatic model_push(input int ch, input int d, output bit st);
    int w, s, e;
    hist[ch].push_back(d);
    if (hist[ch].size() > 16) void'(hist[ch].pop_front());
    w = 1 << cur_win;
    st = hist[ch].size() >= w;
    if (st) begin
      s = 0;
      for (int i = 0; i < w; i++) s += int'(hist[ch][hist[ch].size()-1-i]);
`ifdef STE_AVG_FIR_ROUND_EN
      e = (s + (cur_win == 0 ? 0 : 1 << (cur_win - 1))) / w;
      if (e > 65535) e = 65535;
`else
      e = s / w;
`endif
      last_dout = e;
    end
  endtask
  task automatic send(input int ch, input int d);
    bit st;
    din_i = d[15:0];
    din_ch_i = ch[1:0];
    din_update_i = 1'b1;
    tick();
    din_update_i = 1'b0;
    model_push(ch, d, st);
    chk("ready_busy", ready_o, 0);
    tick();
    chk("strobe_early", dout_update_o, 0);
    tick();
    chk("strobe", dout_update_o, st);
    chk("dout", dout_o, last_dout);
    if (st) chk("dout_ch", dout_ch_o, ch);
    chk("ready_idle", ready_o, 1);
  endtask
  task automatic set_win(input int w);
    int cw;
    win_log2_i = w[2:0];
    tick();
    tick();
    cw = w > 4 ? 4 : w;
    if (cw != cur_win) begin
      cur_win = cw;
      model_clear();
    end
    chk("win_dout", dout_o, last_dout);
  endtask
  initial begin
    bit st;
    int n;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_dout", dout_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_ovr", ovr_o, 0);
    chk("rst_strobe", dout_update_o, 0);
    send(0, 777);
    din_i = 16'd999;
    din_ch_i = 2'd0;
    din_update_i = 1'b1;
    tick();
    din_update_i = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_dout", dout_o, 0);
    chk("rst_mid_ch", dout_ch_o, 0);
    chk("rst_mid_strobe", dout_update_o, 0);
    chk("rst_mid_ready", ready_o, 1);
    rst = 1'b0;
    model_clear();
    tick();
    send(0, 1234);
    chk("tp1_dout", dout_o, 1234);
    set_win(1);
    send(0, 10);
    tick();
    send(0, 20);
    chk("tp2_15", dout_o, 15);
    tick();
    send(0, 30);
    chk("tp2_25", dout_o, 25);
    send(3, 10);
    send(3, 11);
`ifdef STE_AVG_FIR_ROUND_EN
    chk("tp6_round", dout_o, 11);
`else
    chk("tp6_trunc", dout_o, 10);
`endif
    set_win(2);
    for (int i = 0; i < 4; i++) begin
      send(0, 4 * (i + 1));
      if (i == 3) chk("tp3_ch0", dout_o, 10);
      send(2, 100);
      if (i == 3) chk("tp3_ch2", dout_o, 100);
    end
    din_i = 16'd50;
    din_ch_i = 2'd1;
    din_update_i = 1'b1;
    tick();
    din_i = 16'd60;
    tick();
    din_update_i = 1'b0;
    chk("ovr_set", ovr_o, 1);
    model_push(1, 50, st);
    tick();
    chk("ovr_strobe", dout_update_o, st);
    chk("ovr_dout", dout_o, last_dout);
    send(1, 70);
    chk("ovr_sticky", ovr_o, 1);
    avg_clr_i = 1'b1;
    din_update_i = 1'b1;
    tick();
    avg_clr_i = 1'b0;
    din_update_i = 1'b0;
    model_clear();
    chk("clr_ovr", ovr_o, 0);
    chk("clr_dout", dout_o, 0);
    chk("clr_ready", ready_o, 1);
    repeat (3) tick();
    chk("clr_nostrobe", dout_update_o, 0);
    for (int i = 0; i < 4; i++) send(1, 1000 + i);
    set_win(4);
    for (int i = 0; i < 16; i++) send(1, 65535);
    chk("tp5_full", dout_o, 65535);
    set_win(3);
    chk("tp5_clr", dout_o, 0);
    for (int i = 0; i < 8; i++) send(1, int'($urandom_range(0, 65535)));
    set_win(4);
    for (int i = 0; i < 16; i++) send(2, int'($urandom_range(0, 65535)));
    set_win(6);
    send(2, 12345);
    for (int r = 0; r < 4; r++) begin
      set_win(int'($urandom_range(0, 7)));
      repeat (40) begin
        n = int'($urandom_range(0, 2));
        repeat (n) tick();
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
